// File: rtl/rv_pkg.sv
// Shared definitions for the RV fetch front end: widths, state encoding, reset defaults.
package rv_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [63:0]        RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  // Instruction targets must be word aligned; any low bit set is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding fetch, single-entry instruction
// buffer toward execute, deferred control-flow redirects and a sticky alignment fault.
module fetch_ctrl
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               exec_ready,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  fetch_state_e       r_state;
  logic [XLEN-1:0]    r_pc;
  logic               r_imem_req;
  logic [INSTR_W-1:0] r_instr;
  logic [XLEN-1:0]    r_instr_pc;
  logic               r_instr_valid;
  logic               r_fault;
  logic [31:0]        r_fetch_count;
  logic               r_pend;
  logic [XLEN-1:0]    r_pend_pc;

  logic               w_ack;
  logic               w_redir_bad;
  logic               w_redir_ok;
  logic [XLEN-1:0]    w_ack_target;

  assign w_ack        = r_imem_req & imem_ack;
  assign w_redir_bad  = redirect_valid & is_misaligned(redirect_pc[1:0]);
  assign w_redir_ok   = redirect_valid & ~is_misaligned(redirect_pc[1:0]);
  // A redirect arriving with the ack is newer than any pending one.
  assign w_ack_target = w_redir_ok ? redirect_pc : r_pend_pc;

  // Fetch state machine with all outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= {XLEN{1'b0}};
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'd0;
      r_pend        <= 1'b0;
      r_pend_pc     <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_redir_bad) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_pend        <= 1'b0;
          end else if (w_ack) begin
            if (w_redir_ok || r_pend) begin
              // Fetched word belongs to the abandoned path: drop it, refetch.
              r_pc   <= w_ack_target;
              r_pend <= 1'b0;
            end else begin
              r_instr       <= imem_rdata;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_imem_req    <= 1'b0;
              r_state       <= S_HOLD;
            end
          end else begin
            // Address must not move under an open request, so park the target.
            r_imem_req <= 1'b1;
            if (w_redir_ok) begin
              r_pend    <= 1'b1;
              r_pend_pc <= redirect_pc;
            end else begin
              r_pend    <= r_pend;
              r_pend_pc <= r_pend_pc;
            end
          end
        end

        S_HOLD: begin
          if (w_redir_bad) begin
            r_state       <= S_FAULT;
            r_fault       <= 1'b1;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
          end else if (w_redir_ok) begin
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= S_FETCH;
            if (exec_ready) begin
              r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
              r_fetch_count <= r_fetch_count;
            end
          end else if (exec_ready) begin
            r_pc          <= r_pc + XLEN'(4);
            r_instr_valid <= 1'b0;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_imem_req    <= 1'b1;
            r_state       <= S_FETCH;
          end else begin
            r_state <= S_HOLD;
          end
        end

        S_FAULT: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_fault       <= 1'b1;
        end

        default: begin
          r_state       <= S_FAULT;
          r_fault       <= 1'b1;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule
